// File: rtl/blockmem_load_ctrl.sv
// Block-memory load sequencer: streams words into a pointer-addressed memory and hands full blocks to the core.
// Optional: define BLOCK_LOAD_CTRL_STATS_EN to build the blocks_done counter (otherwise tied to zero).
//
// state | meaning
// CLEAR | rewind memory pointer, fill_level -> 0 (one cycle, longer while flush held)
// LOAD  | accept stream words, one memory write per accept
// FULL  | block resident in memory, wait for block_ack
`timescale 1ns/1ps
module blockmem_load_ctrl #(
    parameter int unsigned BLOCK_WORDS = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    input  logic [31:0] in_data,
    output logic        in_ready,
    input  logic        flush,
    output logic        block_valid,
    input  logic        block_ack,
    output logic [8:0]  fill_level,
    output logic [15:0] blocks_done,
    output logic        mem_rst,
    output logic        mem_cs,
    output logic        mem_wr,
    output logic [31:0] mem_wdata
);
    typedef enum logic [1:0] {
        CLEAR = 2'd0,
        LOAD  = 2'd1,
        FULL  = 2'd2
    } state_t;

    localparam logic [8:0] LAST_IDX = 9'(BLOCK_WORDS - 1);

    state_t     state_q, state_d;
    logic [8:0] fill_q, fill_d;
    logic       accept;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= CLEAR;
            fill_q  <= '0;
        end else begin
            state_q <= state_d;
            fill_q  <= fill_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        fill_d      = fill_q;
        in_ready    = 1'b0;
        block_valid = 1'b0;
        mem_rst     = 1'b0;
        accept      = 1'b0;
        case (state_q)
            CLEAR: begin
                mem_rst = 1'b1;
                fill_d  = '0;
                state_d = LOAD;
            end
            LOAD: begin
                in_ready = ~flush;
                accept   = in_valid & ~flush;
                if (accept) begin
                    fill_d = fill_q + 9'd1;
                    if (fill_q == LAST_IDX) begin
                        state_d = FULL;
                    end
                end
            end
            FULL: begin
                block_valid = 1'b1;
                if (block_ack) begin
                    state_d = CLEAR;
                end
            end
            default: begin
                state_d = CLEAR;
            end
        endcase
        // flush outranks both accept and block_ack
        if (flush) begin
            state_d = CLEAR;
            fill_d  = '0;
        end
    end

    assign mem_wr     = accept;
    assign mem_cs     = accept;
    assign mem_wdata  = in_data;
    assign fill_level = fill_q;

`ifdef BLOCK_LOAD_CTRL_STATS_EN
    logic [15:0] blocks_done_q, blocks_done_d;

    always_comb begin
        blocks_done_d = blocks_done_q;
        if ((state_q == FULL) && block_ack && !flush) begin
            blocks_done_d = blocks_done_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            blocks_done_q <= '0;
        end else begin
            blocks_done_q <= blocks_done_d;
        end
    end

    assign blocks_done = blocks_done_q;
`else
    assign blocks_done = 16'h0000;
`endif

endmodule

// File: tb/tb_blockmem_load_ctrl.sv
// Bench for blockmem_load_ctrl: 16-word instance plus a 256-word instance, each with a pointer memory model.
`timescale 1ns/1ps
module tb_blockmem_load_ctrl;
`ifdef BLOCK_LOAD_CTRL_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_n;
    logic        in_valid, flush, block_ack;
    logic [31:0] in_data;
    logic        in_ready, block_valid, mem_rst, mem_cs, mem_wr;
    logic [8:0]  fill_level;
    logic [15:0] blocks_done;
    logic [31:0] mem_wdata;

    logic        in_valid_b, flush_b, block_ack_b;
    logic [31:0] in_data_b;
    logic        in_ready_b, block_valid_b, mem_rst_b, mem_cs_b, mem_wr_b;
    logic [8:0]  fill_level_b;
    logic [15:0] blocks_done_b;
    logic [31:0] mem_wdata_b;

    int          n_cmp = 0;
    int          n_fail = 0;
    logic [15:0] bd_exp = 16'h0;

    typedef struct packed {
        logic [7:0]  addr;
        logic [31:0] data;
    } wr_t;
    wr_t exp_q[$];
    wr_t obs_q[$];

    logic [31:0] mem_a [256];
    logic [7:0]  ptr_a = 8'h0;
    logic [31:0] mem_b [256];
    logic [7:0]  ptr_b = 8'h0;

    blockmem_load_ctrl #(.BLOCK_WORDS(16)) u_dut (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid), .in_data(in_data),
        .in_ready(in_ready), .flush(flush), .block_valid(block_valid), .block_ack(block_ack),
        .fill_level(fill_level), .blocks_done(blocks_done), .mem_rst(mem_rst),
        .mem_cs(mem_cs), .mem_wr(mem_wr), .mem_wdata(mem_wdata)
    );

    blockmem_load_ctrl #(.BLOCK_WORDS(256)) u_dut_b (
        .clk(clk), .reset_n(reset_n), .in_valid(in_valid_b), .in_data(in_data_b),
        .in_ready(in_ready_b), .flush(flush_b), .block_valid(block_valid_b), .block_ack(block_ack_b),
        .fill_level(fill_level_b), .blocks_done(blocks_done_b), .mem_rst(mem_rst_b),
        .mem_cs(mem_cs_b), .mem_wr(mem_wr_b), .mem_wdata(mem_wdata_b)
    );

    // pointer-addressed memory models; writes are also logged for the scoreboard
    always @(posedge clk) begin
        if (mem_wr) obs_q.push_back(wr_t'{ptr_a, mem_wdata});
        if (mem_rst) ptr_a <= 8'h0;
        else begin
            if (mem_wr) mem_a[ptr_a] <= mem_wdata;
            if (mem_cs) ptr_a <= ptr_a + 8'd1;
        end
    end

    always @(posedge clk) begin
        if (mem_rst_b) ptr_b <= 8'h0;
        else begin
            if (mem_wr_b) mem_b[ptr_b] <= mem_wdata_b;
            if (mem_cs_b) ptr_b <= ptr_b + 8'd1;
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; block_ack = 1'b0;
        in_valid_b = 1'b0; in_data_b = '0; flush_b = 1'b0; block_ack_b = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset_n = 1'b1;
        #1;
        n_cmp++;
        if (!(mem_rst === 1'b1 && in_ready === 1'b0 && block_valid === 1'b0)) begin
            n_fail++; $display("FAIL reset_clear: rst/ready/bv got %b%b%b want 100", mem_rst, in_ready, block_valid);
        end
        n_cmp++;
        if (fill_level !== 9'd0 || blocks_done !== 16'd0) begin
            n_fail++; $display("FAIL reset_counts: fill %0d bd %0d want 0 0", fill_level, blocks_done);
        end
        tick;
        n_cmp++;
        if (!(mem_rst === 1'b0 && in_ready === 1'b1 && block_valid === 1'b0 && fill_level === 9'd0)) begin
            n_fail++; $display("FAIL reset_load: rst/ready/bv/fill got %b%b%b/%0d want 010/0", mem_rst, in_ready, block_valid, fill_level);
        end
        n_cmp++;
        if (ptr_a !== 8'd0) begin
            n_fail++; $display("FAIL reset_ptr: got %0d want 0", ptr_a);
        end
    endtask

    task automatic test_stream;
        wr_t e, o;
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1; in_data = 32'h1000 + 32'(k);
            #1;
            n_cmp++;
            if (!(in_ready === 1'b1 && mem_wr === 1'b1 && mem_cs === 1'b1 &&
                  mem_wdata === 32'h1000 + 32'(k) && fill_level === 9'(k))) begin
                n_fail++; $display("FAIL stream_accept%0d: ready/wr/cs/fill got %b%b%b/%0d want 111/%0d",
                                   k, in_ready, mem_wr, mem_cs, fill_level, k);
            end
            exp_q.push_back(wr_t'{8'(k), 32'h1000 + 32'(k)});
            tick;
        end
        in_data = 32'h1010;
        #1;
        n_cmp++;
        if (!(block_valid === 1'b1 && in_ready === 1'b0 && mem_wr === 1'b0 && fill_level === 9'd16)) begin
            n_fail++; $display("FAIL stream_full: bv/ready/wr/fill got %b%b%b/%0d want 100/16", block_valid, in_ready, mem_wr, fill_level);
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL stream_wr_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_fail++; $display("FAIL stream_wr: got addr %0h data %0h want addr %0h data %0h", o.addr, o.data, e.addr, e.data);
            end
        end
        exp_q.delete(); obs_q.delete();
        for (int k = 0; k < 16; k++) begin
            n_cmp++;
            if (mem_a[k] !== 32'h1000 + 32'(k)) begin
                n_fail++; $display("FAIL stream_mem%0d: got %0h want %0h", k, mem_a[k], 32'h1000 + 32'(k));
            end
        end
        n_cmp++;
        if (ptr_a !== 8'd16) begin
            n_fail++; $display("FAIL stream_ptr: got %0d want 16", ptr_a);
        end
    endtask

    task automatic test_full_hold;
        for (int i = 0; i < 10; i++) begin
            n_cmp++;
            if (!(block_valid === 1'b1 && in_ready === 1'b0 && mem_wr === 1'b0 && mem_cs === 1'b0)) begin
                n_fail++; $display("FAIL hold_full%0d: bv/ready/wr/cs got %b%b%b%b want 1000", i, block_valid, in_ready, mem_wr, mem_cs);
            end
            tick;
        end
        n_cmp++;
        if (obs_q.size() != 0 || ptr_a !== 8'd16) begin
            n_fail++; $display("FAIL hold_nowrite: writes %0d ptr %0d want 0 16", obs_q.size(), ptr_a);
        end
        obs_q.delete();
        block_ack = 1'b1; in_valid = 1'b0;
        bd_exp++;
        tick;
        block_ack = 1'b0;
        #1;
        n_cmp++;
        if (!(mem_rst === 1'b1 && block_valid === 1'b0 && in_ready === 1'b0)) begin
            n_fail++; $display("FAIL ack_clear: rst/bv/ready got %b%b%b want 100", mem_rst, block_valid, in_ready);
        end
        n_cmp++;
        if (blocks_done !== (STATS ? bd_exp : 16'h0)) begin
            n_fail++; $display("FAIL ack_count: got %0d want %0d", blocks_done, STATS ? bd_exp : 16'h0);
        end
        tick;
        n_cmp++;
        if (!(in_ready === 1'b1 && mem_rst === 1'b0 && fill_level === 9'd0 && ptr_a === 8'd0)) begin
            n_fail++; $display("FAIL ack_load: ready/rst/fill/ptr got %b%b/%0d/%0d want 10/0/0", in_ready, mem_rst, fill_level, ptr_a);
        end
    endtask

    task automatic test_flush;
        wr_t e, o;
        for (int k = 0; k < 5; k++) begin
            in_valid = 1'b1; in_data = 32'h2000 + 32'(k);
            exp_q.push_back(wr_t'{8'(k), 32'h2000 + 32'(k)});
            tick;
        end
        in_data = 32'h2005; flush = 1'b1;
        #1;
        n_cmp++;
        if (!(in_ready === 1'b0 && mem_wr === 1'b0 && mem_cs === 1'b0)) begin
            n_fail++; $display("FAIL flush_block: ready/wr/cs got %b%b%b want 000", in_ready, mem_wr, mem_cs);
        end
        tick;
        flush = 1'b0; in_valid = 1'b0;
        #1;
        n_cmp++;
        if (!(mem_rst === 1'b1 && fill_level === 9'd0)) begin
            n_fail++; $display("FAIL flush_clear: rst/fill got %b/%0d want 1/0", mem_rst, fill_level);
        end
        tick;
        n_cmp++;
        if (!(in_ready === 1'b1 && mem_rst === 1'b0)) begin
            n_fail++; $display("FAIL flush_load: ready/rst got %b%b want 10", in_ready, mem_rst);
        end
        in_valid = 1'b1; in_data = 32'h2100;
        exp_q.push_back(wr_t'{8'd0, 32'h2100});
        tick;
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL flush_wr_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_fail++; $display("FAIL flush_wr: got addr %0h data %0h want addr %0h data %0h", o.addr, o.data, e.addr, e.data);
            end
        end
        exp_q.delete(); obs_q.delete();
        n_cmp++;
        if (!(mem_a[0] === 32'h2100 && ptr_a === 8'd1 && fill_level === 9'd1)) begin
            n_fail++; $display("FAIL flush_next: mem0 %0h ptr %0d fill %0d want 2100 1 1", mem_a[0], ptr_a, fill_level);
        end
    endtask

    task automatic test_flush_ack;
        wr_t e, o;
        for (int k = 1; k < 16; k++) begin
            in_valid = 1'b1; in_data = 32'h3000 + 32'(k);
            exp_q.push_back(wr_t'{8'(k), 32'h3000 + 32'(k)});
            tick;
        end
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (!(block_valid === 1'b1 && fill_level === 9'd16)) begin
            n_fail++; $display("FAIL fa_full: bv/fill got %b/%0d want 1/16", block_valid, fill_level);
        end
        flush = 1'b1; block_ack = 1'b1;
        tick;
        block_ack = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_cmp++;
            if (!(mem_rst === 1'b1 && in_ready === 1'b0 && block_valid === 1'b0)) begin
                n_fail++; $display("FAIL fa_held%0d: rst/ready/bv got %b%b%b want 100", i, mem_rst, in_ready, block_valid);
            end
            tick;
        end
        flush = 1'b0;
        #1;
        n_cmp++;
        if (mem_rst !== 1'b1) begin
            n_fail++; $display("FAIL fa_last_clear: rst got %b want 1", mem_rst);
        end
        tick;
        n_cmp++;
        if (!(in_ready === 1'b1 && fill_level === 9'd0)) begin
            n_fail++; $display("FAIL fa_load: ready/fill got %b/%0d want 1/0", in_ready, fill_level);
        end
        n_cmp++;
        if (blocks_done !== (STATS ? bd_exp : 16'h0)) begin
            n_fail++; $display("FAIL fa_count: got %0d want %0d", blocks_done, STATS ? bd_exp : 16'h0);
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL fa_wr_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_fail++; $display("FAIL fa_wr: got addr %0h data %0h want addr %0h data %0h", o.addr, o.data, e.addr, e.data);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_back_to_back;
        wr_t e, o;
        for (int k = 0; k < 16; k++) begin
            in_valid = 1'b1; in_data = 32'h4000 + 32'(k);
            exp_q.push_back(wr_t'{8'(k), 32'h4000 + 32'(k)});
            tick;
        end
        block_ack = 1'b1; in_data = 32'h4100;
        bd_exp++;
        tick;
        block_ack = 1'b0;
        #1;
        n_cmp++;
        if (!(mem_rst === 1'b1 && in_ready === 1'b0 && mem_wr === 1'b0)) begin
            n_fail++; $display("FAIL b2b_clear: rst/ready/wr got %b%b%b want 100", mem_rst, in_ready, mem_wr);
        end
        exp_q.push_back(wr_t'{8'd0, 32'h4100});
        tick;
        n_cmp++;
        if (!(in_ready === 1'b1 && mem_wr === 1'b1 && fill_level === 9'd0)) begin
            n_fail++; $display("FAIL b2b_accept: ready/wr/fill got %b%b/%0d want 11/0", in_ready, mem_wr, fill_level);
        end
        tick;
        in_valid = 1'b0;
        #1;
        n_cmp++;
        if (!(fill_level === 9'd1 && blocks_done === (STATS ? bd_exp : 16'h0))) begin
            n_fail++; $display("FAIL b2b_state: fill %0d bd %0d want 1 %0d", fill_level, blocks_done, STATS ? bd_exp : 16'h0);
        end
        n_cmp++;
        if (obs_q.size() != exp_q.size()) begin
            n_fail++; $display("FAIL b2b_wr_count: got %0d want %0d", obs_q.size(), exp_q.size());
        end
        while (exp_q.size() > 0 && obs_q.size() > 0) begin
            e = exp_q.pop_front(); o = obs_q.pop_front(); n_cmp++;
            if (o !== e) begin
                n_fail++; $display("FAIL b2b_wr: got addr %0h data %0h want addr %0h data %0h", o.addr, o.data, e.addr, e.data);
            end
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_reset_mid;
        for (int k = 0; k < 2; k++) begin
            in_valid = 1'b1; in_data = 32'h5000 + 32'(k);
            tick;
        end
        in_valid = 1'b0;
        reset_n = 1'b0;
        bd_exp = 16'h0;
        #1;
        n_cmp++;
        if (!(fill_level === 9'd0 && blocks_done === 16'd0 && mem_rst === 1'b1 && in_ready === 1'b0)) begin
            n_fail++; $display("FAIL midrst: fill %0d bd %0d rst %b ready %b want 0 0 1 0", fill_level, blocks_done, mem_rst, in_ready);
        end
        tick;
        reset_n = 1'b1;
        #1;
        n_cmp++;
        if (mem_rst !== 1'b1) begin
            n_fail++; $display("FAIL midrst_clear: rst got %b want 1", mem_rst);
        end
        tick;
        n_cmp++;
        if (!(in_ready === 1'b1 && fill_level === 9'd0 && ptr_a === 8'd0)) begin
            n_fail++; $display("FAIL midrst_load: ready/fill/ptr got %b/%0d/%0d want 1/0/0", in_ready, fill_level, ptr_a);
        end
        exp_q.delete(); obs_q.delete();
    endtask

    task automatic test_block256;
        for (int k = 0; k < 256; k++) begin
            in_valid_b = 1'b1; in_data_b = 32'hA000_0000 + 32'(k);
            #1;
            n_cmp++;
            if (!(mem_wr_b === 1'b1 && fill_level_b === 9'(k))) begin
                n_fail++; $display("FAIL b256_accept%0d: wr/fill got %b/%0d want 1/%0d", k, mem_wr_b, fill_level_b, k);
            end
            tick;
        end
        in_valid_b = 1'b0;
        #1;
        n_cmp++;
        if (!(fill_level_b === 9'd256 && block_valid_b === 1'b1 && in_ready_b === 1'b0 && ptr_b === 8'd0)) begin
            n_fail++; $display("FAIL b256_full: fill %0d bv %b ready %b ptr %0d want 256 1 0 0", fill_level_b, block_valid_b, in_ready_b, ptr_b);
        end
        for (int k = 0; k < 256; k += 51) begin
            n_cmp++;
            if (mem_b[k] !== 32'hA000_0000 + 32'(k)) begin
                n_fail++; $display("FAIL b256_mem%0d: got %0h want %0h", k, mem_b[k], 32'hA000_0000 + 32'(k));
            end
        end
        n_cmp++;
        if (mem_b[255] !== 32'hA000_00FF) begin
            n_fail++; $display("FAIL b256_mem255: got %0h want a00000ff", mem_b[255]);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_stream;
        test_full_hold;
        test_flush;
        test_flush_ack;
        test_back_to_back;
        test_reset_mid;
        test_block256;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
